// File: rtl/minisys_pkg.sv
// minisys_pkg
//   Shared definitions for the Minisys execute-stage multiply/divide unit.
//   - R-type funct codes that the HI/LO unit responds to.
//   - State encoding of the iterative multiply/divide sequencer.
//   - Small decode helpers shared by the top level.
package minisys_pkg;

  // R-type funct field values (instruction bits [5:0]).
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Sequencer states.
  //   MD_IDLE : waiting for a request; mthi/mtlo complete here in one edge.
  //   MD_RUN  : one radix-2 multiply or divide step per cycle.
  //   MD_FIX  : sign correction and HI/LO write-back.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // True for the four iterative operations 18h..1Bh.
  function automatic logic is_md_op(input logic [5:0] fn);
    return (fn[5:2] == 4'b0110);
  endfunction

  // Division ops have funct bit 1 set (1Ah/1Bh); multiplies have it clear.
  function automatic logic is_div_op(input logic [5:0] fn);
    return fn[1];
  endfunction

  // Signed variants (mult/div) have funct bit 0 clear.
  function automatic logic is_signed_op(input logic [5:0] fn);
    return ~fn[0];
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step
//   Combinational single-iteration datapath shared by multiply and divide.
//   The working state is one 2*WIDTH register {upper, lower}:
//     multiply : upper = partial product high half, lower = multiplier bits
//                not yet consumed (LSB first). Each step conditionally adds
//                the multiplicand into the upper half and shifts the whole
//                register right one bit, so after WIDTH steps it holds the
//                full unsigned product.
//     divide   : upper = partial remainder, lower = dividend bits not yet
//                consumed (MSB first) with quotient bits entering from the
//                right. Each step is one restoring-division step.
// Ports
//   is_div    in   1        0 = multiply step, 1 = divide step
//   part_i    in   2*WIDTH  current working state
//   operand_i in   WIDTH    multiplicand (mult) or divisor magnitude (div)
//   part_o    out  2*WIDTH  working state after this step
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] part_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] part_o
);

  logic [WIDTH:0] add_sum;   // upper half + (multiplier bit ? multiplicand : 0)
  logic [WIDTH:0] shl_rem;   // remainder shifted left with next dividend bit
  logic [WIDTH:0] trial;     // shl_rem - divisor; MSB set means it went negative

  always_comb begin
    add_sum = {1'b0, part_i[2*WIDTH-1:WIDTH]}
            + (part_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    shl_rem = {part_i[2*WIDTH-1:WIDTH], part_i[WIDTH-1]};
    trial   = shl_rem - {1'b0, operand_i};
    part_o  = {2*WIDTH{1'b0}};

    if (is_div) begin
      // With remainder < divisor, a non-negative trial always fits in WIDTH
      // bits, so the top bit of the (WIDTH+1)-bit difference is the borrow.
      if (!trial[WIDTH]) begin
        part_o = {trial[WIDTH-1:0], part_i[WIDTH-2:0], 1'b1};
      end else begin
        part_o = {shl_rem[WIDTH-1:0], part_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new MSB as everything shifts right.
      part_o = {add_sum, part_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div32.sv
// mult_div32
//   Multi-cycle multiply/divide unit for the Minisys execute stage. Owns the
//   HI/LO registers, executes mult/multu/div/divu iteratively (one radix-2
//   step per cycle) and mthi/mtlo in a single edge, and serves mfhi/mflo
//   reads combinationally.
//
// Request/response handshake:
//   Start is a request strobe that is only looked at while Busy is low
//   (sequencer in IDLE). A mult/div request accepted at edge k raises Busy
//   after edge k; Busy stays high for 33 cycles and falls after edge k+33,
//   the same edge that writes HI/LO and raises Done for exactly one cycle.
//   Any Start seen while Busy is high, mthi/mtlo included, is dropped.
//   A Start in the cycle Done is high is accepted (the unit is back in IDLE).
//   HI/LO keep their previous values until write-back, so MF_Result is
//   stale while Busy; holding off mfhi/mflo is the pipeline's job.
//
// Ports
//   clock            in   1      rising-edge clock
//   reset            in   1      asynchronous active-high reset
//   Start            in   1      request strobe
//   Function_opcode  in   6      R-type funct (10h..13h, 18h..1Bh)
//   Read_data_1      in   32     rs: multiplicand / dividend / mthi,mtlo data
//   Read_data_2      in   32     rt: multiplier / divisor
//   Busy             out  1      operation in flight (registered)
//   Done             out  1      one-cycle pulse when HI/LO take a result
//   HI, LO           out  32     architectural HI/LO registers
//   MF_Result        out  32     LO when funct is 12h, otherwise HI
module mult_div32
  import minisys_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               ITER    = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       Function_opcode,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MF_Result
);

  localparam int               CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  // Sequencer and architectural state.
  md_state_e          state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Working registers of the operation in flight.
  logic [2*WIDTH-1:0] part_q, part_d;      // product / {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand / divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d; // product or quotient negated
  logic               neg_rem_q, neg_rem_d; // remainder follows dividend sign
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   rs_q, rs_d;          // raw dividend, HI on divide-by-zero

  // Operand decode for an incoming request.
  logic               req_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Write-back values computed from the finished working state.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [2*WIDTH-1:0] part_step;

  md_step #(
    .WIDTH (WIDTH)
  ) u_md_step (
    .is_div    (is_div_q),
    .part_i    (part_q),
    .operand_i (opnd_q),
    .part_o    (part_step)
  );

  always_comb begin
    // Defaults: hold everything, no Done pulse.
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    part_d    = part_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    rs_d      = rs_q;

    // Signed ops work on magnitudes; the signs are reapplied in FIX.
    // abs(80000000h) is 80000000h read as unsigned, which is exactly right.
    req_signed = is_signed_op(Function_opcode);
    a_neg      = req_signed & Read_data_1[WIDTH-1];
    b_neg      = req_signed & Read_data_2[WIDTH-1];
    a_mag      = a_neg ? (~Read_data_1 + 1'b1) : Read_data_1;
    b_mag      = b_neg ? (~Read_data_2 + 1'b1) : Read_data_2;

    prod_fix = neg_res_q ? (~part_q + 1'b1) : part_q;
    quo_fix  = neg_res_q ? (~part_q[WIDTH-1:0] + 1'b1) : part_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~part_q[2*WIDTH-1:WIDTH] + 1'b1)
                         : part_q[2*WIDTH-1:WIDTH];

    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          if (Function_opcode == FN_MTHI) begin
            hi_d = Read_data_1;
          end else if (Function_opcode == FN_MTLO) begin
            lo_d = Read_data_1;
          end else if (is_md_op(Function_opcode)) begin
            // Both mult and div seed the low half with |rs| and keep |rt|
            // as the step operand; multiplication commutes, so the
            // multiplier/multiplicand roles need no distinction.
            part_d    = {{WIDTH{1'b0}}, a_mag};
            opnd_d    = b_mag;
            is_div_d  = is_div_op(Function_opcode);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = (Read_data_2 == {WIDTH{1'b0}});
            rs_d      = Read_data_1;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = MD_RUN;
          end
        end
      end

      MD_RUN: begin
        part_d = part_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          // Divide-by-zero still takes the full latency; result is fixed.
          hi_d = rs_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase

    // Busy is registered, tracking the state being entered.
    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      part_q    <= {2*WIDTH{1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      rs_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      rs_q      <= rs_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign MF_Result = (Function_opcode == FN_MFLO) ? lo_q : hi_q;

endmodule

// File: tb/tb_mult_div32.sv
// tb_mult_div32
//   Self-checking bench for mult_div32: table of directed vectors, a few
//   random vectors checked against a behavioural model, and hand-written
//   sequences for mfhi/mflo, mthi/mtlo, Start-while-Busy and mid-run reset.
module tb_mult_div32;
  import minisys_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic [5:0]  Function_opcode;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MF_Result;

  always #5 clock = ~clock;

  mult_div32 dut (
    .clock           (clock),
    .reset           (reset),
    .Start           (Start),
    .Function_opcode (Function_opcode),
    .Read_data_1     (Read_data_1),
    .Read_data_2     (Read_data_2),
    .Busy            (Busy),
    .Done            (Done),
    .HI              (HI),
    .LO              (LO),
    .MF_Result       (MF_Result)
  );

  // ---------------- scoreboard ----------------
  int          total    = 0;
  int          passed   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] last_hi, last_lo;
  logic [31:0] mon_hi, mon_lo;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Result monitor: every Done pulse must match the oldest pending result.
  always @(negedge clock) begin
    if (Done === 1'b1) begin
      done_cnt++;
      if (exp_hi_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got Done=1 with HI=%08h LO=%08h expected no pending result", HI, LO);
      end else begin
        mon_hi = exp_hi_q.pop_front();
        mon_lo = exp_lo_q.pop_front();
        check("result_hi", HI, mon_hi);
        check("result_lo", LO, mon_lo);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0]        up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    case (op)
      FN_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      FN_MULTU: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      FN_DIV: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      end
      FN_DIVU: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: ;
    endcase
  endtask

  // ---------------- drivers ----------------
  // Drive one request for one cycle; returns at the negedge after the
  // accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    Start           = 1'b1;
    Function_opcode = op;
    Read_data_1     = a;
    Read_data_2     = b;
    @(negedge clock);
    Start           = 1'b0;
    Function_opcode = 6'h00;
  endtask

  // Count negedge samples with Busy high, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic run_md(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int d0;
    exp_hi_q.push_back(ehi);
    exp_lo_q.push_back(elo);
    d0 = done_cnt;
    issue(op, a, b);
    wait_idle(cyc);
    check({name, "_busy_cycles"}, 32'(cyc), 32'd33);
    @(negedge clock);
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_done_low"}, {31'd0, Done}, 32'd0);
    last_hi = ehi;
    last_lo = elo;
  endtask

  task automatic add_vec(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    int          d0;
    logic [5:0]  rop;
    logic [31:0] ra, rb, rhi, rlo;

    add_vec("multu_max",   FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    add_vec("mult_m3x5",   FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    add_vec("div_m7_2",    FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec("divu_100_7",  FN_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    add_vec("div_ovf",     FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add_vec("div_by0",     FN_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
    add_vec("div_neg_by0", FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    add_vec("divu_by0",    FN_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    add_vec("mult_min_sq", FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add_vec("div_7_m2",    FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    add_vec("divu_big",    FN_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    add_vec("mult_7_m2",   FN_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2);

    reset           = 1'b1;
    Start           = 1'b0;
    Function_opcode = 6'h00;
    Read_data_1     = '0;
    Read_data_2     = '0;
    last_hi         = '0;
    last_lo         = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_hi",   HI, 32'd0);
    check("reset_lo",   LO, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      run_md(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Random vectors against the model.
    for (int i = 0; i < 6; i++) begin
      rop = 6'h18 + 6'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      if (i == 0) rb = rb & 32'h000000FF;
      model(rop, ra, rb, rhi, rlo);
      run_md("rand", rop, ra, rb, rhi, rlo);
    end

    // mfhi / mflo after a signed multiply.
    run_md("mult_m3x5_mf", FN_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    Function_opcode = FN_MFHI;
    #1 check("mfhi", MF_Result, 32'hFFFFFFFF);
    Function_opcode = FN_MFLO;
    #1 check("mflo", MF_Result, 32'hFFFFFFF1);
    Function_opcode = 6'h00;

    // mthi / mtlo in IDLE take effect after one edge without Busy.
    issue(FN_MTHI, 32'h5A5A5A5A, 32'h0);
    check("mthi_hi",   HI, 32'h5A5A5A5A);
    check("mthi_lo",   LO, last_lo);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    last_hi = 32'h5A5A5A5A;
    issue(FN_MTLO, 32'hA5A5A5A5, 32'h0);
    check("mtlo_lo",   LO, 32'hA5A5A5A5);
    check("mtlo_hi",   HI, last_hi);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    last_lo = 32'hA5A5A5A5;

    // mfhi as a Start request changes nothing.
    issue(FN_MFHI, 32'h12345678, 32'h9);
    check("mf_start_hi",   HI, last_hi);
    check("mf_start_lo",   LO, last_lo);
    check("mf_start_busy", {31'd0, Busy}, 32'd0);

    // mtlo issued while Busy is dropped; HI/LO stale during the run.
    exp_hi_q.push_back(32'h00000000);
    exp_lo_q.push_back(32'h01000000);
    d0 = done_cnt;
    issue(FN_MULTU, 32'h00001000, 32'h00001000);
    repeat (4) @(negedge clock);
    check("run_hi_stale", HI, last_hi);
    check("run_lo_stale", LO, last_lo);
    check("run_busy",     {31'd0, Busy}, 32'd1);
    Start           = 1'b1;
    Function_opcode = FN_MTLO;
    Read_data_1     = 32'hDEADBEEF;
    @(negedge clock);
    Start           = 1'b0;
    Function_opcode = 6'h00;
    wait_idle(cyc);
    check("busy_mtlo_cycles", 32'(cyc + 5), 32'd33);
    @(negedge clock);
    check("busy_mtlo_done", 32'(done_cnt - d0), 32'd1);
    last_hi = 32'h00000000;
    last_lo = 32'h01000000;

    // Reset in the middle of a divu: state cleared at once, no Done.
    run_md("pre_reset", FN_MULTU, 32'h00010001, 32'h00010001, 32'h00000001, 32'h00020001);
    d0 = done_cnt;
    issue(FN_DIVU, 32'h00001000, 32'h00000003);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_hi",   HI, 32'd0);
    check("midrst_lo",   LO, 32'd0);
    check("midrst_done", {31'd0, Done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_md("post_reset", FN_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    check("queue_empty", 32'(exp_hi_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: got no end of test expected completion before 500000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div32.md
Name: mult_div32

Overview:
- Multi-cycle multiply/divide responder for the Minisys execute stage.
- Accepts mult/multu/div/divu/mthi/mtlo requests from the execute stage and owns the HI/LO registers.
- Serves mfhi/mflo reads combinationally.
- Raises Busy so the pipeline stalls while an iterative operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.
- ITER, 32, iterations per mult/div; must equal WIDTH.
- DIV0_LO, 32'hFFFFFFFF, LO value written on divide-by-zero.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  request strobe; sampled only in IDLE.
- Function_opcode  input  6  R-type funct: 10h mfhi, 11h mthi, 12h mflo, 13h mtlo, 18h mult, 19h multu, 1Ah div, 1Bh divu.
- Read_data_1  input  32  rs operand (multiplicand/dividend; source for mthi/mtlo).
- Read_data_2  input  32  rt operand (multiplier/divisor).
- Busy  output  1  high while an operation is in flight; Start is ignored while high.
- Done  output  1  one-cycle registered pulse when HI/LO take a mult/div result.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MF_Result  output  32  LO if Function_opcode==12h, else HI; combinational.

Behaviour:
- Reset (async, any state): state=IDLE; HI=LO=0; Busy=0; Done=0; iteration counter=0; working regs=0. An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start with 11h: HI<=Read_data_1 at this edge. Start with 13h: LO<=Read_data_1. Both take effect next cycle, no Busy.
  - Start with 18h–1Bh: latch magnitudes (abs for signed ops, raw for unsigned), result sign, remainder sign, divisor-zero flag; counter=0; go RUN.
  - Start with any other funct (including 10h/12h): no state change.
- RUN: one radix-2 step per cycle.
  - mult: shift-add into a 64-bit product.
  - div: restoring step (shift remainder, trial subtract, set quotient bit).
  - Counter increments; after step ITER-1 (counter==31), go FIX.
- FIX:
  - mult: negate 64-bit product if result sign set.
  - div: quotient negated if operand signs differ; remainder takes dividend's sign.
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient); Done<=1 for exactly one cycle; go IDLE.
- Divide-by-zero: still runs the full latency; FIX writes LO=DIV0_LO, HI=Read_data_1 as latched.
- Signed overflow 80000000h / FFFFFFFFh: LO=80000000h, HI=0; no exception.
- Busy = (state!=IDLE), registered. Timing for Start accepted at edge k:
  - Busy high from after edge k until after edge k+33 (33 cycles).
  - HI/LO and Done valid after edge k+33.
- A new Start in the same cycle Done is high is accepted (state is IDLE).
- HI/LO hold old values throughout RUN/FIX; MF_Result during Busy returns stale data. Stalling mfhi/mflo is the controller's responsibility.
- Start while Busy: ignored entirely, including mthi/mtlo.

Decomposition:
- Shared package (minisys_pkg): funct constants FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU; state enum encoding.
- Sub-module md_step: combinational single-iteration datapath.
  - Inputs: mode, partial product/remainder, operand.
  - Outputs: next partial state.
  - Instantiated once inside the RUN loop.

Test Plan:
- multu FFFFFFFFh × FFFFFFFFh -> Busy 33 cycles; HI=FFFFFFFEh, LO=00000001h; Done one pulse.
- mult -3 (FFFFFFFDh) × 5 -> HI=FFFFFFFFh, LO=FFFFFFF1h. Then mfhi via Function_opcode=10h -> MF_Result=FFFFFFFFh.
- div -7 / 2 -> LO=FFFFFFFDh, HI=FFFFFFFFh.
- divu 100 / 7 -> LO=0000000Eh, HI=00000002h.
- div 80000000h / FFFFFFFFh -> LO=80000000h, HI=0.
- div 1234h / 0 -> LO=FFFFFFFFh, HI=00001234h.
- mthi 5A5A5A5Ah in IDLE -> HI next cycle, Busy stays 0.
- mtlo Start issued while Busy -> ignored; LO unchanged at completion.
- Assert reset at RUN cycle 10 of a divu -> Busy=0, HI=LO=0 immediately, no Done. A following multu 2×3 yields LO=6, HI=0.
